// File: rtl/dma_fpram.sv
// dma_fpram: copies len+1 words from DRAM into FPRAM (CRAM or SFILE).
// Ports: start/tgt/src/dst/len request, dram_* read port, dma_* write port, busy/done.
module dma_fpram (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        tgt,
  input  logic [20:0] src,
  input  logic [7:0]  dst,
  input  logic [7:0]  len,
  output logic        dram_req,
  output logic [20:0] dram_addr,
  input  logic        dram_next,
  input  logic [15:0] dram_rdata,
  input  logic        dram_stb,
  output logic [15:0] dma_data,
  output logic [7:0]  dma_wraddr,
  output logic        dma_cram_we,
  output logic        dma_sfile_we,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic        tgt_q;
  logic [20:0] src_ptr;
  logic [7:0]  dst_ptr;
  logic [7:0]  issue_cnt;
  logic [7:0]  recv_cnt;
  logic        last_q;
  logic        issue;
  logic        recv;

  assign dram_req  = (state == READ);
  assign dram_addr = src_ptr;
  assign busy      = (state != IDLE);
  assign issue     = dram_req && dram_next;
  // last_q marks the final word's write cycle; any
  // further strobes are stray and must not write
  assign recv      = busy && !last_q && dram_stb;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = READ;
      READ:    if (issue && issue_cnt == 8'd0)
                 state_nx = DRAIN;
      DRAIN:   if (last_q) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q        <= 1'b0;
      src_ptr      <= '0;
      dst_ptr      <= '0;
      issue_cnt    <= '0;
      recv_cnt     <= '0;
      last_q       <= 1'b0;
      dma_data     <= '0;
      dma_wraddr   <= '0;
      dma_cram_we  <= 1'b0;
      dma_sfile_we <= 1'b0;
      done         <= 1'b0;
    end else begin
      dma_cram_we  <= 1'b0;
      dma_sfile_we <= 1'b0;
      done         <= 1'b0;
      last_q       <= 1'b0;
      if (state == IDLE && start) begin
        tgt_q     <= tgt;
        src_ptr   <= src;
        dst_ptr   <= dst;
        issue_cnt <= len;
        recv_cnt  <= len;
      end
      if (issue) begin
        src_ptr <= src_ptr + 21'd1;
        if (issue_cnt != 8'd0)
          issue_cnt <= issue_cnt - 8'd1;
      end
      if (recv) begin
        dma_data     <= dram_rdata;
        dma_wraddr   <= dst_ptr;
        dst_ptr      <= dst_ptr + 8'd1;
        dma_cram_we  <= !tgt_q;
        dma_sfile_we <= tgt_q;
        if (recv_cnt == 8'd0) last_q <= 1'b1;
        else recv_cnt <= recv_cnt - 8'd1;
      end
      // done lands the cycle after the last write
      if (state == DRAIN && last_q)
        done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_fpram.sv
// tb_dma_fpram: directed bench for dma_fpram with a small
// DRAM responder queue returning words in request order.
module tb_dma_fpram;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        tgt;
  logic [20:0] src;
  logic [7:0]  dst;
  logic [7:0]  len;
  logic        dram_req;
  logic [20:0] dram_addr;
  logic        dram_next;
  logic [15:0] dram_rdata;
  logic        dram_stb;
  logic [15:0] dma_data;
  logic [7:0]  dma_wraddr;
  logic        dma_cram_we;
  logic        dma_sfile_we;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          dly;
    logic [15:0] d;
  } rd_t;

  rd_t         pq[$];
  int          g_iss;
  int          g_n;
  logic [20:0] g_src;
  logic [15:0] g_base;

  logic        nx_t;
  logic [20:0] nx_s;
  logic [7:0]  nx_d;
  logic [7:0]  nx_l;

  always #5 clk = ~clk;

  dma_fpram dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .tgt         (tgt),
    .src         (src),
    .dst         (dst),
    .len         (len),
    .dram_req    (dram_req),
    .dram_addr   (dram_addr),
    .dram_next   (dram_next),
    .dram_rdata  (dram_rdata),
    .dram_stb    (dram_stb),
    .dma_data    (dma_data),
    .dma_wraddr  (dma_wraddr),
    .dma_cram_we (dma_cram_we),
    .dma_sfile_we(dma_sfile_we),
    .busy        (busy),
    .done        (done)
  );

  task automatic kick(input logic t, input logic [20:0] s,
                      input logic [7:0] d, input logic [7:0] l);
    start = 1'b1;
    tgt   = t;
    src   = s;
    dst   = d;
    len   = l;
  endtask

  // Called at a negedge: drives DRAM inputs for the next edge.
  task automatic drive_dram(input bit stall);
    rd_t         e;
    logic [20:0] ea;
    foreach (pq[i]) pq[i].dly--;
    dram_stb = 1'b0;
    if (pq.size() > 0 && pq[0].dly <= 0 &&
        (!stall || $urandom_range(0, 2) != 0)) begin
      e          = pq.pop_front();
      dram_stb   = 1'b1;
      dram_rdata = e.d;
    end
    dram_next = 1'b0;
    if (dram_req === 1'b1 && g_iss < g_n &&
        (!stall || $urandom_range(0, 3) != 0)) begin
      ea = g_src + 21'(g_iss);
      checks++;
      if (dram_addr !== ea) begin
        errors++;
        $display("FAIL dram_addr issue %0d: got %h, want %h",
                 g_iss, dram_addr, ea);
      end
      dram_next = 1'b1;
      e.dly = 2;
      e.d   = g_base + 16'(g_iss);
      pq.push_back(e);
      g_iss++;
    end
  endtask

  task automatic check_idle_zero(input string nm);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dram_req !== 1'b0 ||
        dma_cram_we !== 1'b0 || dma_sfile_we !== 1'b0 ||
        dma_data !== 16'h0 || dma_wraddr !== 8'h0 ||
        dram_addr !== 21'h0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b req=%b cw=%b sw=%b data=%h wa=%h da=%h, want all 0",
               nm, busy, done, dram_req, dma_cram_we, dma_sfile_we,
               dma_data, dma_wraddr, dram_addr);
    end
  endtask

  // Entered at a negedge where start was already driven.
  task automatic run_xfer(input logic t, input logic [20:0] s,
                          input logic [7:0] d, input logic [7:0] l,
                          input logic [15:0] base, input bit stall,
                          input bit chain, input bit poke,
                          input int abort_at, input string nm);
    int          wr;
    int          dn;
    int          cyc;
    int          lastw;
    bit          fin;
    logic [7:0]  ea;
    logic [15:0] ed;
    g_iss  = 0;
    g_n    = int'(l) + 1;
    g_src  = s;
    g_base = base;
    wr     = 0;
    dn     = 0;
    cyc    = 0;
    lastw  = -10;
    fin    = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (poke && (cyc == 3 || cyc == 9))
        kick(~t, 21'h0, d + 8'h40, 8'h0);
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy_after_start: got %b, want 1", nm, busy);
        end
      end
      if (dma_cram_we === 1'b1 || dma_sfile_we === 1'b1) begin
        ea = d + 8'(wr);
        ed = base + 16'(wr);
        checks++;
        if (dma_cram_we !== !t || dma_sfile_we !== t ||
            dma_data !== ed || dma_wraddr !== ea || wr >= g_n) begin
          errors++;
          $display("FAIL %s write %0d: cw=%b sw=%b data=%h addr=%h, want cw=%b sw=%b data=%h addr=%h",
                   nm, wr, dma_cram_we, dma_sfile_we, dma_data,
                   dma_wraddr, !t, t, ed, ea);
        end
        wr++;
        lastw = cyc;
      end
      if (done === 1'b1) begin
        checks++;
        if (wr != g_n || busy !== 1'b0 || lastw != cyc - 1 ||
            dram_req !== 1'b0) begin
          errors++;
          $display("FAIL %s done: writes=%0d busy=%b gap=%0d req=%b, want writes=%0d busy=0 gap=1 req=0",
                   nm, wr, busy, cyc - lastw, dram_req, g_n);
        end
        dn++;
        fin = 1'b1;
        if (chain) kick(nx_t, nx_s, nx_d, nx_l);
      end else if (abort_at >= 0 && wr == abort_at) begin
        rst       = 1'b1;
        dram_next = 1'b0;
        dram_stb  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero({nm, " after_rst"});
        repeat (12) begin
          drive_dram(1'b0);
          @(negedge clk);
          checks++;
          if (dma_cram_we !== 1'b0 || dma_sfile_we !== 1'b0 ||
              done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s late_stb: cw=%b sw=%b done=%b busy=%b, want 0",
                     nm, dma_cram_we, dma_sfile_we, done, busy);
          end
        end
        checks++;
        if (pq.size() != 0) begin
          errors++;
          $display("FAIL %s late_stb_sent: pending=%0d, want 0",
                   nm, pq.size());
        end
        fin = 1'b1;
      end else begin
        drive_dram(stall);
      end
      if (!fin && cyc > 4000) begin
        errors++;
        $display("FAIL %s timeout: writes=%0d, want %0d done", nm, wr, g_n);
        fin = 1'b1;
      end
    end
    dram_next = 1'b0;
    dram_stb  = 1'b0;
    if (!chain && dn == 1) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 ||
          dma_cram_we !== 1'b0 || dma_sfile_we !== 1'b0) begin
        errors++;
        $display("FAIL %s done_pulse: done=%b busy=%b cw=%b sw=%b, want 0",
                 nm, done, busy, dma_cram_we, dma_sfile_we);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_zero("reset_state");
    rst = 1'b0;
    dram_stb   = 1'b1;
    dram_rdata = 16'hDEAD;
    @(negedge clk);
    dram_stb = 1'b0;
    @(negedge clk);
    check_idle_zero("idle_stb_ignored");
  endtask

  task automatic test_cram;
    kick(1'b0, 21'h00100, 8'h10, 8'd3);
    run_xfer(1'b0, 21'h00100, 8'h10, 8'd3, 16'hA000,
             1'b0, 1'b0, 1'b0, -1, "cram");
  endtask

  task automatic test_sfile_wrap;
    kick(1'b1, 21'h01234, 8'hFE, 8'd2);
    run_xfer(1'b1, 21'h01234, 8'hFE, 8'd2, 16'h5100,
             1'b0, 1'b0, 1'b0, -1, "sfile_wrap");
  endtask

  task automatic test_long_stall;
    kick(1'b0, 21'h1FFFFF, 8'h80, 8'hFF);
    run_xfer(1'b0, 21'h1FFFFF, 8'h80, 8'hFF, 16'h3000,
             1'b1, 1'b0, 1'b0, -1, "long_stall");
  endtask

  task automatic test_busy_ignore;
    kick(1'b1, 21'h00040, 8'h20, 8'd5);
    run_xfer(1'b1, 21'h00040, 8'h20, 8'd5, 16'h7700,
             1'b0, 1'b0, 1'b1, -1, "busy_ignore");
  endtask

  task automatic test_back_to_back;
    nx_t = 1'b1;
    nx_s = 21'h0ABCD;
    nx_d = 8'h33;
    nx_l = 8'd1;
    kick(1'b0, 21'h00200, 8'h08, 8'd2);
    run_xfer(1'b0, 21'h00200, 8'h08, 8'd2, 16'h1100,
             1'b0, 1'b1, 1'b0, -1, "b2b_first");
    run_xfer(1'b1, 21'h0ABCD, 8'h33, 8'd1, 16'h2200,
             1'b0, 1'b0, 1'b0, -1, "b2b_second");
  endtask

  task automatic test_abort;
    kick(1'b0, 21'h00300, 8'h50, 8'd3);
    run_xfer(1'b0, 21'h00300, 8'h50, 8'd3, 16'hC000,
             1'b0, 1'b0, 1'b0, 2, "abort");
    pq.delete();
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    tgt        = 1'b0;
    src        = '0;
    dst        = '0;
    len        = '0;
    dram_next  = 1'b0;
    dram_rdata = '0;
    dram_stb   = 1'b0;
    g_iss      = 0;
    g_n        = 0;
    g_src      = '0;
    g_base     = '0;
    nx_t       = 1'b0;
    nx_s       = '0;
    nx_d       = '0;
    nx_l       = '0;
    test_reset;
    test_cram;
    test_sfile_wrap;
    test_long_stall;
    test_busy_ignore;
    test_back_to_back;
    test_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
